spi_master: RTL
===============

# spi_master

SPI mode-3 (CPOL=1, CPHA=1) master that executes one full-duplex transfer per request from `sequencer` and drives the accelerometer pins. It accepts a right-aligned MOSI word and a bit count, shifts MSB-first with chip select held low for the whole transfer, and returns the right-aligned MISO word. It sits directly between `sequencer` and the board SPI pins.

## Interface
- `CLK_DIV`, 4: SCK half-period in `clk_in` cycles; legal range 1..255.
- `clk_in`  in  1  system clock; all logic on rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `spi_request`  in  1  transfer request from `sequencer`.
- `spi_ready`  out  1  high = idle and able to accept; low = transfer in progress or awaiting request release.
- `spi_nbits`  in  6  bit count minus 1; values 32..63 are treated as 31.
- `spi_mosi_data`  in  32  transmit word, right-aligned; bit `spi_nbits` is sent first.
- `spi_miso_data`  out  32  receive word, right-aligned; the last bit received is in bit 0.
- `spi_csn`  out  1  chip select, active low.
- `spi_sck`  out  1  serial clock; idles high.
- `spi_mosi`  out  1  serial data out.
- `spi_miso`  in  1  serial data in.

## Operation
- Reset values: `spi_ready`=1, `spi_csn`=1, `spi_sck`=1, `spi_mosi`=0, `spi_miso_data`=0, state IDLE, all counters 0.
- Let N = min(`spi_nbits`, 31) + 1 be the number of bits in the transfer.
- IDLE: `spi_ready`=1. When `spi_request`=1 at a clock edge:
  - latch `spi_mosi_data` and N;
  - clear the receive shift register;
  - set `spi_ready`<=0 and `spi_csn`<=0;
  - go to LEAD.
- LEAD (CS setup): hold for CLK_DIV cycles. On the last cycle, set `spi_sck`<=0 and `spi_mosi`<=first bit, then go to LOW.
- LOW: hold for CLK_DIV cycles. On the last cycle:
  - set `spi_sck`<=1;
  - sample `spi_miso` into the receive shift register (shift left, new bit into bit 0);
  - go to HIGH.
- HIGH: hold for CLK_DIV cycles. On the last cycle:
  - if bits remain, set `spi_sck`<=0, `spi_mosi`<=next bit, and go to LOW;
  - otherwise go to TRAIL.
- TRAIL (CS hold): hold for CLK_DIV cycles with `spi_sck`=1. On the last cycle, set `spi_csn`<=1, `spi_miso_data`<=receive register, and go to GAP.
- GAP (deselect time): hold for CLK_DIV cycles, then go to DONE.
- DONE: when `spi_request`=0, set `spi_ready`<=1 and go to IDLE. If the request is still high, stay in DONE.
- `spi_miso_data` updates only in TRAIL→GAP and holds until the next transfer completes. Bits [31:N] are 0.
- `spi_miso` is sampled unconverted, so X or Z propagates to `spi_miso_data` in simulation (`sequencer` relies on this to check 8'hzz).
- `spi_request` and `spi_mosi_data` changes after acceptance are ignored.
- After leaving reset mid-transfer, the block is idle: `spi_csn`=1 and `spi_sck`=1. No partial result is reported.

## Timing
- Acceptance: request sampled high at edge k. At edge k, `spi_ready`=0 and `spi_csn`=0.
- First SCK falling edge occurs CLK_DIV cycles after `spi_csn` falls.
- Each bit takes 2·CLK_DIV cycles. MOSI changes with SCK falling; MISO is sampled at SCK rising.
- `spi_csn` is low for CLK_DIV·(2N+2) cycles.
- `spi_ready` is low for CLK_DIV·(2N+3) cycles, provided the request was already released. Otherwise it stays low until the first edge after the request is seen low, plus one cycle.
- `spi_miso_data` is valid CLK_DIV cycles before `spi_ready` rises.
- `spi_sck` and `spi_mosi` are registered outputs, glitch-free.
- Minimum CS-high time between transfers is CLK_DIV+1 cycles.

## Test plan
- Read, CLK_DIV=2, nbits=15, mosi=0x8F00, slave returns 0x33 on bits 7:0:
  - MOSI bit stream is 1000_1111_0000_0000;
  - `spi_miso_data`=0x0000xx33;
  - `spi_csn` low for 68 cycles;
  - `spi_ready` low for 70 cycles.
- Read, nbits=23, mosi=0xE80000, slave returns address byte Z, then 0x9A, then 0x12:
  - `spi_miso_data`[15:8]=0x9A and [7:0]=0x12;
  - 24 SCK pulses.
- Request held high for 200 cycles after acceptance (CLK_DIV=1, nbits=7):
  - exactly one transfer;
  - `spi_ready` stays 0 until the cycle after the request drops.
- nbits=40:
  - 32 SCK pulses;
  - MOSI starts with `spi_mosi_data`[31].
- Reset asserted during bit 5 of a 16-bit transfer:
  - `spi_csn`=1, `spi_sck`=1, `spi_ready`=1 immediately;
  - `spi_miso_data`=0;
  - the next request runs a clean full transfer.
- Back-to-back transfers driven by `sequencer` with a mode-3 slave model: WHO_AM_I, three writes, then repeated X_L reads all pass without `$fatal`.

Source files
------------

// File: rtl/spi_master_if.sv
// Sequencer-side bus of the mode-3 SPI master: request/ready handshake plus
// right-aligned transmit word, bit count and received word.
interface spi_master_if;
  logic        spi_request;
  logic        spi_ready;
  logic [5:0]  spi_nbits;
  logic [31:0] spi_mosi_data;
  logic [31:0] spi_miso_data;

  modport master (
    output spi_request,
    output spi_nbits,
    output spi_mosi_data,
    input  spi_ready,
    input  spi_miso_data
  );

  modport slave (
    input  spi_request,
    input  spi_nbits,
    input  spi_mosi_data,
    output spi_ready,
    output spi_miso_data
  );
endinterface

// File: rtl/spi_master.sv
// SPI mode-3 (CPOL=1, CPHA=1) master: one MSB-first full-duplex transfer of
// 1..32 bits per request, chip select held low for the whole transfer.
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk_in,
  input  logic        nrst,
  spi_master_if.slave bus,
  output logic        spi_csn,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_LOW,
    S_HIGH,
    S_TRAIL,
    S_GAP,
    S_DONE
  } state_t;

  state_t      r_state, w_state;
  logic [7:0]  r_divCnt, w_divCnt;
  logic [5:0]  r_bitCnt, w_bitCnt;
  logic [31:0] r_txShift, w_txShift;
  logic [31:0] r_rxShift, w_rxShift;
  logic [31:0] r_misoData, w_misoData;
  logic        r_csn, w_csn;
  logic        r_sck, w_sck;
  logic        r_mosi, w_mosi;
  logic        r_ready, w_ready;
  logic [4:0]  w_lastIdx;
  logic        w_phaseEnd;

  // Bit counts above 32 collapse to a full 32-bit word.
  assign w_lastIdx  = bus.spi_nbits[5] ? 5'd31 : bus.spi_nbits[4:0];
  assign w_phaseEnd = (r_divCnt == DIV_LAST);

  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_divCnt   <= '0;
      r_bitCnt   <= '0;
      r_txShift  <= '0;
      r_rxShift  <= '0;
      r_misoData <= '0;
      r_csn      <= 1'b1;
      r_sck      <= 1'b1;
      r_mosi     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_divCnt   <= w_divCnt;
      r_bitCnt   <= w_bitCnt;
      r_txShift  <= w_txShift;
      r_rxShift  <= w_rxShift;
      r_misoData <= w_misoData;
      r_csn      <= w_csn;
      r_sck      <= w_sck;
      r_mosi     <= w_mosi;
      r_ready    <= w_ready;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_bitCnt   = r_bitCnt;
    w_txShift  = r_txShift;
    w_rxShift  = r_rxShift;
    w_misoData = r_misoData;
    w_csn      = r_csn;
    w_sck      = r_sck;
    w_mosi     = r_mosi;
    w_ready    = r_ready;
    w_divCnt   = (w_phaseEnd || r_state == S_IDLE || r_state == S_DONE) ?
                 8'd0 : r_divCnt + 8'd1;

    case (r_state)
      S_IDLE: begin
        if (bus.spi_request) begin
          // Left-justify the word so the first bit to send sits in bit 31.
          w_txShift = bus.spi_mosi_data << (5'd31 - w_lastIdx);
          w_bitCnt  = {1'b0, w_lastIdx} + 6'd1;
          w_rxShift = '0;
          w_ready   = 1'b0;
          w_csn     = 1'b0;
          w_state   = S_LEAD;
        end
      end
      S_LEAD: begin
        if (w_phaseEnd) begin
          w_sck     = 1'b0;
          w_mosi    = r_txShift[31];
          w_txShift = {r_txShift[30:0], 1'b0};
          w_bitCnt  = r_bitCnt - 6'd1;
          w_state   = S_LOW;
        end
      end
      S_LOW: begin
        if (w_phaseEnd) begin
          w_sck     = 1'b1;
          w_rxShift = {r_rxShift[30:0], spi_miso};
          w_state   = S_HIGH;
        end
      end
      S_HIGH: begin
        if (w_phaseEnd) begin
          if (r_bitCnt != 6'd0) begin
            w_sck     = 1'b0;
            w_mosi    = r_txShift[31];
            w_txShift = {r_txShift[30:0], 1'b0};
            w_bitCnt  = r_bitCnt - 6'd1;
            w_state   = S_LOW;
          end else begin
            w_state = S_TRAIL;
          end
        end
      end
      S_TRAIL: begin
        if (w_phaseEnd) begin
          w_csn      = 1'b1;
          w_misoData = r_rxShift;
          w_state    = S_GAP;
        end
      end
      S_GAP: begin
        // The end of the deselect time doubles as the first DONE check.
        if (w_phaseEnd) begin
          if (!bus.spi_request) begin
            w_ready = 1'b1;
            w_state = S_IDLE;
          end else begin
            w_state = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!bus.spi_request) begin
          w_ready = 1'b1;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign spi_csn           = r_csn;
  assign spi_sck           = r_sck;
  assign spi_mosi          = r_mosi;
  assign bus.spi_ready     = r_ready;
  assign bus.spi_miso_data = r_misoData;

endmodule
